// File: rtl/mbist_pkg.sv
// ---------------------------------------------------------------------------
// mbist_pkg
// Shared definitions for the March C- memory BIST controller:
//   - mbist_state_t : controller FSM state encoding
//   - NUM_ELEM      : number of March elements (E0..E5)
//   - ELEM_*        : per-element constant tables, bit e describes element e
//   - BG0 / BG1     : solid data backgrounds
//   - first_op()    : entry state of an element (read first, or write only)
// ---------------------------------------------------------------------------
package mbist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_CMP,
        WR,
        DONE
    } mbist_state_t;

    localparam int NUM_ELEM = 6;

    localparam logic [7:0] BG0 = 8'h00;
    localparam logic [7:0] BG1 = 8'hFF;

    // March C-:  E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)
    //            E3 dn(r0,w1)  E4 dn(r1,w0)  E5 up(r0)
    // Bit e of each table belongs to element e.
    localparam logic [NUM_ELEM-1:0] ELEM_UP     = 6'b100111; // 1 = ascending addresses
    localparam logic [NUM_ELEM-1:0] ELEM_HAS_RD = 6'b111110;
    localparam logic [NUM_ELEM-1:0] ELEM_HAS_WR = 6'b011111;
    localparam logic [NUM_ELEM-1:0] ELEM_RD_ONE = 6'b010100; // read expects BG1
    localparam logic [NUM_ELEM-1:0] ELEM_WR_ONE = 6'b001010; // write uses BG1

    // An element starts each address with its read if it has one.
    function automatic mbist_state_t first_op(input logic [2:0] elem);
        return ELEM_HAS_RD[elem] ? RD_ISSUE : WR;
    endfunction

endpackage

// File: rtl/mbist_sram_mux.sv
// ---------------------------------------------------------------------------
// mbist_sram_mux
// Combinational 2:1 selection of the SRAM pins. While busy the BIST
// controller owns the port, otherwise the functional port passes straight
// through with no register stage.
// Ports:
//   busy                       select (1 = controller)
//   sys_ramaddr/ramin/rwbar/cs functional request
//   ctl_ramaddr/ramin/rwbar/cs controller request
//   ramaddr/ramin/rwbar/cs     SRAM pins
// ---------------------------------------------------------------------------
module mbist_sram_mux #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              busy,
    input  logic [ADDR_W-1:0] sys_ramaddr,
    input  logic [DATA_W-1:0] sys_ramin,
    input  logic              sys_rwbar,
    input  logic              sys_cs,
    input  logic [ADDR_W-1:0] ctl_ramaddr,
    input  logic [DATA_W-1:0] ctl_ramin,
    input  logic              ctl_rwbar,
    input  logic              ctl_cs,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramin,
    output logic              rwbar,
    output logic              cs
);

    assign ramaddr = busy ? ctl_ramaddr : sys_ramaddr;
    assign ramin   = busy ? ctl_ramin   : sys_ramin;
    assign rwbar   = busy ? ctl_rwbar   : sys_rwbar;
    assign cs      = busy ? ctl_cs      : sys_cs;

endmodule

// File: rtl/mbist_controller.sv
// ---------------------------------------------------------------------------
// mbist_controller
// March C- built-in self-test for a single-port SRAM (default 64x8) using
// solid 00/FF backgrounds. On start it takes over the SRAM port, runs the
// six March elements and reports pass/fail plus the first failing address
// and read data. When not busy the functional port drives the SRAM.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    run request (ignored while busy)
//   sys_ramaddr/ramin/rwbar/cs  functional SRAM request
//   ramout                   SRAM read data
//   ramaddr/ramin/rwbar/cs   SRAM pins
//   busy, done, fail         status (done and fail held until start/rst)
//   fail_addr, fail_data     first miscompare address / read value
//   err_count                (MBIST_DIAG_EN only) saturating miscompare count
//
// Build option MBIST_DIAG_EN: run to completion counting every miscompare.
// Without it the run stops at the first miscompare.
// ---------------------------------------------------------------------------
module mbist_controller
    import mbist_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] sys_ramaddr,
    input  logic [DATA_W-1:0] sys_ramin,
    input  logic              sys_rwbar,
    input  logic              sys_cs,
    input  logic [DATA_W-1:0] ramout,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramin,
    output logic              rwbar,
    output logic              cs,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
`ifdef MBIST_DIAG_EN
    ,
    output logic [7:0]        err_count
`endif
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [2:0]        LAST_ELEM = 3'(NUM_ELEM - 1);

    mbist_state_t      state;
    logic [2:0]        elem;
    logic [ADDR_W-1:0] addr_cnt;

    // Controller-side SRAM request, decoded from registered state.
    logic [ADDR_W-1:0] ctl_ramaddr;
    logic [DATA_W-1:0] ctl_ramin;
    logic              ctl_rwbar;

    // Where to go after the last operation at the current address.
    mbist_state_t      adv_state;
    logic [2:0]        adv_elem;
    logic [ADDR_W-1:0] adv_addr;
    logic              adv_finish;

    logic [DATA_W-1:0] exp_data;
    logic              miscompare;
    logic              abort;

    assign ctl_ramaddr = addr_cnt;
    assign ctl_ramin   = {DATA_W{ELEM_WR_ONE[elem]}};
    assign ctl_rwbar   = (state != WR);
    assign exp_data    = {DATA_W{ELEM_RD_ONE[elem]}};
    assign miscompare  = (ramout != exp_data);

`ifdef MBIST_DIAG_EN
    assign abort = 1'b0;
`else
    assign abort = miscompare;
`endif

    // NOTE: every output of this block gets a default first, so no path
    // through the ifs leaves a variable unassigned (which would infer a latch).
    always_comb begin
        adv_state  = first_op(elem);
        adv_elem   = elem;
        adv_addr   = addr_cnt;
        adv_finish = 1'b0;
        if ((ELEM_UP[elem] && addr_cnt == ADDR_MAX) ||
            (!ELEM_UP[elem] && addr_cnt == '0)) begin
            if (elem == LAST_ELEM) begin
                adv_state  = DONE;
                adv_finish = 1'b1;
            end else begin
                adv_elem  = elem + 3'd1;
                adv_addr  = ELEM_UP[elem + 3'd1] ? '0 : ADDR_MAX;
                adv_state = first_op(elem + 3'd1);
            end
        end else begin
            adv_addr = ELEM_UP[elem] ? addr_cnt + 1'b1 : addr_cnt - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before this edge regardless of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            elem      <= '0;
            addr_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_data <= '0;
`ifdef MBIST_DIAG_EN
            err_count <= '0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= first_op(3'd0);
                        elem      <= '0;
                        addr_cnt  <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_data <= '0;
`ifdef MBIST_DIAG_EN
                        err_count <= '0;
`endif
                    end
                end

                RD_ISSUE: state <= RD_CMP;

                RD_CMP: begin
                    // Only the first miscompare of a run is captured.
                    if (miscompare && !fail) begin
                        fail      <= 1'b1;
                        fail_addr <= addr_cnt;
                        fail_data <= ramout;
                    end
`ifdef MBIST_DIAG_EN
                    if (miscompare && err_count != 8'hFF)
                        err_count <= err_count + 8'd1;
`endif
                    if (abort) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (ELEM_HAS_WR[elem]) begin
                        state <= WR;
                    end else begin
                        state    <= adv_state;
                        elem     <= adv_elem;
                        addr_cnt <= adv_addr;
                        if (adv_finish) begin
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end

                WR: begin
                    state    <= adv_state;
                    elem     <= adv_elem;
                    addr_cnt <= adv_addr;
                    if (adv_finish) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    mbist_sram_mux #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_mux (
        .busy        (busy),
        .sys_ramaddr (sys_ramaddr),
        .sys_ramin   (sys_ramin),
        .sys_rwbar   (sys_rwbar),
        .sys_cs      (sys_cs),
        .ctl_ramaddr (ctl_ramaddr),
        .ctl_ramin   (ctl_ramin),
        .ctl_rwbar   (ctl_rwbar),
        .ctl_cs      (1'b1),
        .ramaddr     (ramaddr),
        .ramin       (ramin),
        .rwbar       (rwbar),
        .cs          (cs)
    );

endmodule

// File: tb/tb_mbist_controller.sv
// ---------------------------------------------------------------------------
// tb_mbist_controller
// Drives mbist_controller against a behavioural 64x8 SRAM with injectable
// stuck-at bits. Expected results come from a March C- model that walks the
// element list over a plain array and counts cycles per operation.
// Works with or without MBIST_DIAG_EN.
// ---------------------------------------------------------------------------
module tb_mbist_controller;
    import mbist_pkg::*;

`ifdef MBIST_DIAG_EN
    localparam bit DIAG = 1'b1;
`else
    localparam bit DIAG = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [5:0] sys_ramaddr;
    logic [7:0] sys_ramin;
    logic       sys_rwbar;
    logic       sys_cs;
    logic [7:0] ramout;
    logic [5:0] ramaddr;
    logic [7:0] ramin;
    logic       rwbar;
    logic       cs;
    logic       busy;
    logic       done;
    logic       fail;
    logic [5:0] fail_addr;
    logic [7:0] fail_data;
`ifdef MBIST_DIAG_EN
    logic [7:0] err_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mbist_controller #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .sys_ramaddr (sys_ramaddr),
        .sys_ramin   (sys_ramin),
        .sys_rwbar   (sys_rwbar),
        .sys_cs      (sys_cs),
        .ramout      (ramout),
        .ramaddr     (ramaddr),
        .ramin       (ramin),
        .rwbar       (rwbar),
        .cs          (cs),
        .busy        (busy),
        .done        (done),
        .fail        (fail),
        .fail_addr   (fail_addr),
        .fail_data   (fail_data)
`ifdef MBIST_DIAG_EN
        ,
        .err_count   (err_count)
`endif
    );

    // ---------------- behavioural SRAM with stuck-at bits ----------------
    logic [7:0] mem [64];
    logic [7:0] sa0 [64];
    logic [7:0] sa1 [64];
    logic [5:0] addr_q = '0;

    function automatic logic [7:0] stored(input int a, input logic [7:0] d);
        return (d & ~sa0[a]) | sa1[a];
    endfunction

    always @(posedge clk) begin
        if (cs) begin
            addr_q <= ramaddr;
            if (!rwbar) mem[ramaddr] <= stored(int'(ramaddr), ramin);
        end
    end

    assign ramout = (cs && rwbar) ? mem[addr_q] : 8'h00;

    // ---------------- reference March C- model ----------------
    int         e_up [6] = '{1, 1, 1, 0, 0, 1};
    int         e_rd [6] = '{-1, 0, 1, 0, 1, 0};   // -1 = no read
    int         e_wr [6] = '{0, 1, 0, 1, 0, -1};   // -1 = no write
    logic [7:0] m_mem [64];
    int         m_total, m_nerr, m_first_cycle, m_first_addr;
    logic [7:0] m_first_data;

    task automatic run_model();
        int cyc = 0;
        m_nerr = 0;
        m_first_cycle = 0;
        m_first_addr = 0;
        m_first_data = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 64; k++) begin
                int a = (e_up[e] != 0) ? k : 63 - k;
                if (e_rd[e] >= 0) begin
                    logic [7:0] want = (e_rd[e] != 0) ? BG1 : BG0;
                    cyc += 2;
                    if (m_mem[a] != want) begin
                        m_nerr++;
                        if (m_nerr == 1) begin
                            m_first_cycle = cyc;
                            m_first_addr  = a;
                            m_first_data  = m_mem[a];
                        end
                    end
                end
                if (e_wr[e] >= 0) begin
                    cyc += 1;
                    m_mem[a] = stored(a, (e_wr[e] != 0) ? BG1 : BG0);
                end
            end
        end
        m_total = cyc;
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_faults();
        foreach (sa0[i]) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    // Random functional traffic while idle; pins must follow sys_* exactly.
    task automatic idle_traffic(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            sys_ramaddr = 6'($urandom);
            sys_ramin   = 8'($urandom);
            sys_rwbar   = 1'($urandom);
            sys_cs      = 1'($urandom);
            #1;
            check({tag, "_pins"}, {ramaddr, ramin, rwbar, cs},
                  {sys_ramaddr, sys_ramin, sys_rwbar, sys_cs});
        end
        @(negedge clk);
        sys_cs = 1'b0;
    endtask

    // One BIST run. restart_at / reset_at name a busy cycle (0 = never).
    task automatic run_march(input string tag, input int restart_at, input int reset_at);
        int n = 0;
        int exp_len;
        run_model();
        exp_len = (!DIAG && m_nerr > 0) ? m_first_cycle : m_total;

        @(negedge clk);
        start = 1'b1;
        // Functional port stays active to show the mux ignores it while busy.
        sys_cs      = 1'b1;
        sys_rwbar   = 1'b0;
        sys_ramaddr = 6'($urandom);
        sys_ramin   = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        check({tag, "_first_wr"}, {busy, done, fail, ramaddr, ramin, rwbar, cs},
              {1'b1, 1'b0, 1'b0, 6'd0, BG0, 1'b0, 1'b1});

        while (busy === 1'b1 && n < 2000) begin
            n++;
            start = (n == restart_at);
            if (n == reset_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check({tag, "_rst_status"}, {busy, done, fail, fail_addr, fail_data},
                      {1'b0, 1'b0, 1'b0, 6'd0, 8'd0});
                sys_cs = 1'b0;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;

        check({tag, "_busy_len"}, n, exp_len);
        check({tag, "_done"}, {busy, done}, 2'b01);
        check({tag, "_fail"}, fail, (m_nerr > 0));
        if (m_nerr > 0) begin
            check({tag, "_fail_addr"}, fail_addr, m_first_addr);
            check({tag, "_fail_data"}, fail_data, m_first_data);
        end
`ifdef MBIST_DIAG_EN
        check({tag, "_err_count"}, err_count, (m_nerr > 255) ? 255 : m_nerr);
`endif
        if (exp_len == m_total) begin
            int bad = 0;
            foreach (mem[i]) if (mem[i] != m_mem[i]) bad++;
            check({tag, "_mem_bad_words"}, bad, 0);
        end
        sys_cs = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        start = 1'b0;
        sys_ramaddr = '0;
        sys_ramin = '0;
        sys_rwbar = 1'b1;
        sys_cs = 1'b0;
        clear_faults();
        foreach (mem[i]) mem[i] = 8'($urandom);

        repeat (3) @(negedge clk);
        check("reset_status", {busy, done, fail, fail_addr, fail_data},
              {1'b0, 1'b0, 1'b0, 6'd0, 8'd0});
`ifdef MBIST_DIAG_EN
        check("reset_err_count", err_count, 0);
`endif
        rst = 1'b0;

        // Functional write then read of address 7 through the idle mux.
        @(negedge clk);
        sys_cs = 1'b1; sys_rwbar = 1'b0; sys_ramaddr = 6'd7; sys_ramin = 8'hA5;
        #1;
        check("idle_wr_pins", {ramaddr, ramin, rwbar, cs}, {6'd7, 8'hA5, 1'b0, 1'b1});
        @(negedge clk);
        sys_rwbar = 1'b1;
        @(negedge clk);
        check("idle_rd_data", ramout, 8'hA5);
        idle_traffic("idle", 8);

        run_march("clean", 0, 0);

        sa0[5][2] = 1'b1;
        run_march("sa0_a5b2", 0, 0);

        sa0[40][6] = 1'b1;
        run_march("sa0_a5_a40", 0, 0);

        clear_faults();
        run_march("restart_ignored", 100, 0);
        run_march("mid_reset", 0, 300);
        run_march("after_reset", 0, 0);

        for (int it = 0; it < 6; it++) begin
            int nf = $urandom_range(0, 3);
            clear_faults();
            for (int f = 0; f < nf; f++) begin
                int a = $urandom_range(0, 63);
                int b = $urandom_range(0, 7);
                if ($urandom_range(0, 1) != 0) sa0[a][b] = 1'b1;
                else                           sa1[a][b] = 1'b1;
            end
            idle_traffic($sformatf("rnd%0d_idle", it), $urandom_range(1, 5));
            run_march($sformatf("rnd%0d", it), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
